bouncebox_src: RTL and testbench

//  Upstream pixel source for the llhdmi HDMI encoder, a drop-in alternative to vgatestsrc.

---
 rtl/bouncebox_src.sv | 106 ++++++++++
 tb/tb_bouncebox_src.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bouncebox_src.sv
// rtl/bouncebox_src.sv - bouncing white box over a gradient with a red border, fed to the HDMI encoder
// Raster position follows the encoder strobes; o_pixel is registered from the next-state counters.
module bouncebox_src #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 32,
  parameter int STEP     = 2
) (
  input  logic        i_pixclk,
  input  logic        i_reset,
  input  logic        i_rd,
  input  logic        i_newline,
  input  logic        i_newframe,
  output logic [23:0] o_pixel
);

  localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
  localparam logic [11:0] X_STOP = 12'(H_ACTIVE - BOX_W);
  localparam logic [11:0] Y_STOP = 12'(V_ACTIVE - BOX_H);
  localparam logic [11:0] STEP_W = 12'(STEP);

  logic [11:0] col_q, col_d, row_q, row_d;
  logic [11:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  frm_q, frm_d;
  logic [23:0] pixel_q, pixel_d;

  // Returns {direction, position} after one frame of motion along one axis.
  function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dir,
                                         input logic [11:0] stop);
    logic [12:0] sum;
    sum = {1'b0, pos} + {1'b0, STEP_W};
    if (dir) begin
      if (sum >= {1'b0, stop}) return {1'b0, stop};
      else                     return {1'b1, sum[11:0]};
    end else begin
      if (pos <= STEP_W) return {1'b1, 12'd0};
      else               return {1'b0, pos - STEP_W};
    end
  endfunction

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    bx_d  = bx_q;
    by_d  = by_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    frm_d = frm_q;
    if (i_newframe) begin
      col_d          = 12'd0;
      row_d          = 12'd0;
      frm_d          = frm_q + 8'd1;
      {dx_d, bx_d}   = bounce(bx_q, dx_q, X_STOP);
      {dy_d, by_d}   = bounce(by_q, dy_q, Y_STOP);
    end else if (i_newline) begin
      col_d = 12'd0;
      if (row_q < V_LIM) row_d = row_q + 12'd1;
    end else if (i_rd) begin
      if (col_q < H_LIM) col_d = col_q + 12'd1;
    end
  end

  logic [12:0] bx_end, by_end;
  logic        in_box, on_border;

  always_comb begin
    bx_end    = {1'b0, bx_d} + 13'(BOX_W);
    by_end    = {1'b0, by_d} + 13'(BOX_H);
    in_box    = (col_d >= bx_d) && ({1'b0, col_d} < bx_end) &&
                (row_d >= by_d) && ({1'b0, row_d} < by_end);
    on_border = (col_d == 12'd0) || (col_d == H_LIM - 12'd1) ||
                (row_d == 12'd0) || (row_d == V_LIM - 12'd1);
    pixel_d   = {col_d[7:0], row_d[7:0], frm_d};
    if (col_d >= H_LIM || row_d >= V_LIM) pixel_d = 24'h000000;
    else if (in_box)                      pixel_d = 24'hFFFFFF;
    else if (on_border)                   pixel_d = 24'hFF0000;
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      col_q   <= 12'd0;
      row_q   <= 12'd0;
      bx_q    <= 12'd0;
      by_q    <= 12'd0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      frm_q   <= 8'd0;
      pixel_q <= 24'h000000;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      frm_q   <= frm_d;
      pixel_q <= pixel_d;
    end
  end

  assign o_pixel = pixel_q;

endmodule

// File: tb/tb_bouncebox_src.sv
// tb/tb_bouncebox_src.sv - directed vector bench for bouncebox_src
module tb_bouncebox_src;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_rd, i_newline, i_newframe;
  logic [23:0] o_pixel;

  int total = 0;
  int bad   = 0;

  bouncebox_src dut (
    .i_pixclk   (clk),
    .i_reset    (i_reset),
    .i_rd       (i_rd),
    .i_newline  (i_newline),
    .i_newframe (i_newframe),
    .o_pixel    (o_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nf;
    logic        nl;
    logic        rd;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [23:0] exp);
    total++;
    if (o_pixel !== exp) begin
      bad++;
      $display("FAIL %s: got %06h want %06h", name, o_pixel, exp);
    end
  endtask

  task automatic step(input logic nf, input logic nl, input logic rd);
    i_newframe = nf;
    i_newline  = nl;
    i_rd       = rd;
    @(posedge clk);
    #1;
    i_newframe = 1'b0;
    i_newline  = 1'b0;
    i_rd       = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic nf, input logic nl, input logic rd);
    for (int k = 0; k < n; k++) step(nf, nl, rd);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'hFF0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'hFF0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 24'h010101};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 24'h020101};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 24'h030101};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 24'h040101};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 24'h050101};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'hFF0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 24'h010201};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 24'hFF0000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 24'hFF0000};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 24'h010102};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 24'hFF0000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 24'h010202};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 24'h020202};

    i_reset    = 1'b1;
    i_rd       = 1'b0;
    i_newline  = 1'b0;
    i_newframe = 1'b0;
    #1;
    check("reset_black", 24'h000000);
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].nf, vecs[i].nl, vecs[i].rd);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Row 3, then 100 columns in: gradient for (100,3), frame 2.
    step(1'b0, 1'b1, 1'b0);
    repeat_step(100, 1'b0, 1'b0, 1'b1);
    check("pre_reset_col100", 24'h640302);
    i_reset = 1'b1;
    #1;
    check("reset_async_black", 24'h000000);
    @(posedge clk);
    #1;
    check("reset_held_black", 24'h000000);
    i_reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("post_reset_box_at_origin", 24'hFFFFFF);

    // Column saturation on row 1 of frame 1 (box at 2,2).
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(639, 1'b0, 1'b0, 1'b1);
    check("col639_border", 24'hFF0000);
    step(1'b0, 1'b0, 1'b1);
    check("col640_black", 24'h000000);
    repeat_step(60, 1'b0, 1'b0, 1'b1);
    check("col_saturated_black", 24'h000000);
    step(1'b0, 1'b1, 1'b0);
    check("newline_after_sat", 24'hFF0000);
    step(1'b0, 1'b0, 1'b1);
    check("row2_col1", 24'h010201);

    // Frame 304 since reset: box reaches bx=608 (right edge), by=288 on its way back up.
    repeat_step(303, 1'b1, 1'b0, 1'b0);
    check("frame304_origin", 24'hFF0000);
    repeat_step(288, 1'b0, 1'b1, 1'b0);
    repeat_step(607, 1'b0, 1'b0, 1'b1);
    check("f304_left_of_box", 24'h5F2030);
    step(1'b0, 1'b0, 1'b1);
    check("f304_box_at_608", 24'hFFFFFF);
    repeat_step(31, 1'b0, 1'b0, 1'b1);
    check("f304_box_col639", 24'hFFFFFF);
    step(1'b0, 1'b0, 1'b1);
    check("f304_col640_black", 24'h000000);

    // Frame 305: box reversed to bx=606, by=286.
    step(1'b1, 1'b0, 1'b0);
    repeat_step(286, 1'b0, 1'b1, 1'b0);
    repeat_step(605, 1'b0, 1'b0, 1'b1);
    check("f305_left_of_box", 24'h5D1E31);
    step(1'b0, 1'b0, 1'b1);
    check("f305_box_at_606", 24'hFFFFFF);
    repeat_step(31, 1'b0, 1'b0, 1'b1);
    check("f305_box_col637", 24'hFFFFFF);
    step(1'b0, 1'b0, 1'b1);
    check("f305_right_of_box", 24'h7E1E31);

    // Row saturation: newlines past the last line give black.
    repeat_step(193, 1'b0, 1'b1, 1'b0);
    check("row479_border", 24'hFF0000);
    step(1'b0, 1'b1, 1'b0);
    check("row480_black", 24'h000000);
    repeat_step(10, 1'b0, 1'b1, 1'b0);
    check("row_saturated_black", 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
